seq_limb_mul: RTL and testbench

Parametrised multi-cycle large-integer multiplier. It generalises the single-shot parallel multiplier to configurable operand width and limb width, adds a signed/unsigned mode, and adds valid/ready handshakes on input and output. Operand B is consumed one limb per cycle, accumulating into a 2*WIDTH product. The block sits between an operand source (register file or bus adapter) and a result consumer in the big-number datapath.

---
 rtl/mul_pkg.sv | 19 +
 rtl/limb_mac.sv | 17 +
 rtl/seq_limb_mul.sv | 109 ++++++++++
 tb/tb_seq_limb_mul.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding and sizing helpers for the limb multiplier
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit limb_split_ok(input int w, input int l);
    return (l > 0) && ((w % l) == 0) && (w >= 2 * l);
  endfunction

endpackage

// File: rtl/limb_mac.sv
// rtl/limb_mac.sv - combinational WIDTH x LIMB multiply plus high-accumulator add
module limb_mac #(
  parameter int WIDTH = 1024,
  parameter int LIMB  = 64
) (
  input  logic [WIDTH-1:0]      a,
  input  logic [LIMB-1:0]       b,
  input  logic [WIDTH-1:0]      acc_hi,
  output logic [WIDTH+LIMB-1:0] sum
);

  localparam int SW = WIDTH + LIMB;

  // a*b + acc_hi < 2^(WIDTH+LIMB), so SW bits never overflow
  assign sum = (SW'(a) * SW'(b)) + SW'(acc_hi);

endmodule

// File: rtl/seq_limb_mul.sv
// rtl/seq_limb_mul.sv - multi-cycle signed/unsigned multiplier consuming one limb of B per cycle
module seq_limb_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 1024,
  parameter int LIMB  = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod
);

  localparam int N_LIMBS = WIDTH / LIMB;
  localparam int CW      = cnt_width(N_LIMBS);
  localparam int PW      = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_CNT = CW'(N_LIMBS - 1);

  if (!limb_split_ok(WIDTH, LIMB)) begin : g_cfg_bad
    $error("seq_limb_mul: WIDTH must be a multiple of LIMB and at least 2*LIMB");
  end

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [PW-1:0]           acc;
  logic [WIDTH-1:0]        mag_a;
  logic [WIDTH-1:0]        mag_b;
  logic                    neg;
  logic [WIDTH+LIMB-1:0]   sum;
  logic [WIDTH-1:0]        a_abs;
  logic [WIDTH-1:0]        b_abs;

  // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude
  assign a_abs = (in_signed && in_a[WIDTH-1]) ? (~in_a + WIDTH'(1)) : in_a;
  assign b_abs = (in_signed && in_b[WIDTH-1]) ? (~in_b + WIDTH'(1)) : in_b;

  limb_mac #(
    .WIDTH (WIDTH),
    .LIMB  (LIMB)
  ) u_mac (
    .a      (mag_a),
    .b      (mag_b[LIMB-1:0]),
    .acc_hi (acc[PW-1:WIDTH]),
    .sum    (sum)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_prod  <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      mag_a     <= '0;
      mag_b     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            mag_a    <= a_abs;
            mag_b    <= b_abs;
            neg      <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_MUL;
          end
        end
        ST_MUL: begin
          // low limb of the new partial sum drops into the finished low half
          acc   <= {sum, acc[WIDTH-1:LIMB]};
          mag_b <= mag_b >> LIMB;
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            state <= ST_FIX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_FIX: begin
          out_prod  <= neg ? (~acc + PW'(1)) : acc;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_limb_mul.sv
// tb/tb_seq_limb_mul.sv - self-checking bench for seq_limb_mul with directed table and random operands
module tb_seq_limb_mul;

  localparam int W  = 1024;
  localparam int L  = 64;
  localparam int PW = 2 * W;

  logic           clk = 1'b0;
  logic           rstn;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_signed;
  logic           out_valid;
  logic           out_ready;
  logic [PW-1:0]  out_prod;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_limb_mul #(.WIDTH(W), .LIMB(L)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod)
  );

  typedef struct {
    string         name;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          s;
    logic [PW-1:0] exp;
    int            hold;
  } vec_t;

  vec_t tv[$];

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [PW-1:0] sa;
    logic signed [PW-1:0] sb;
    logic [PW-1:0]        ua;
    logic [PW-1:0]        ub;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    ua = PW'(a);
    ub = PW'(b);
    return ua * ub;
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h",
               name, act[PW-1 -: 64], act[63:0], exp[PW-1 -: 64], exp[63:0]);
    end
  endtask

  task automatic add_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [PW-1:0] exp, input int hold);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.s = s; v.exp = exp; v.hold = hold;
    tv.push_back(v);
  endtask

  // entered at a negedge; leaves the DUT back in IDLE at a negedge
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [PW-1:0] exp, input int hold);
    int            n;
    logic          busy_bad;
    logic          stable;
    logic [PW-1:0] held;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready_before"}, PW'(in_ready), PW'(1));
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = {32{$urandom}};
    in_b = ~in_a;
    in_signed = ~s;
    n = 1;
    busy_bad = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, PW'(n), PW'(18));
    chk({name, " in_ready_busy"}, PW'(busy_bad | in_ready), PW'(0));
    chk({name, " product"}, out_prod, exp);
    held = out_prod;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_prod !== held) stable = 1'b0;
    end
    if (hold > 0) chk({name, " backpressure_stable"}, PW'(stable), PW'(1));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " back_to_idle"}, PW'({out_valid, in_ready}), PW'(2'b01));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0]  m44;
    logic [W-1:0]  m2_1023;
    logic [W-1:0]  ones;
    logic [PW-1:0] e;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic          rs;
    logic          no_pulse;

    rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_signed = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", PW'(in_ready), PW'(1));
    chk("reset out_valid", PW'(out_valid), PW'(0));
    chk("reset out_prod", out_prod, '0);
    rstn = 1'b0;
    @(negedge clk);

    m44     = '0; m44 = m44 - W'(44);
    m2_1023 = W'(1) << (W - 1);
    ones    = '1;
    add_vec("u44x55", W'(44), W'(55), 1'b0, PW'(2420), 0);
    add_vec("u4345x45345", W'(4345), W'(45345), 1'b0, PW'(197024025), 0);
    add_vec("u44x33_b2b", W'(44), W'(33), 1'b0, PW'(1452), 0);
    e = '0; e = e - (PW'(1) << (W + 1)) + PW'(1);
    add_vec("u_allones", ones, ones, 1'b0, e, 0);
    e = '0; e = e - PW'(2420);
    add_vec("s_m44x55", m44, W'(55), 1'b1, e, 0);
    add_vec("s_min_sq", m2_1023, m2_1023, 1'b1, PW'(1) << (PW - 2), 0);
    e = '0; e = e - (PW'(1) << (W - 1));
    add_vec("s_min_x1", m2_1023, W'(1), 1'b1, e, 0);
    add_vec("s_m44x0", m44, '0, 1'b1, '0, 0);
    add_vec("u0xones", '0, ones, 1'b0, '0, 0);
    add_vec("u_backpressure", W'(7), W'(9), 1'b0, PW'(63), 5);

    foreach (tv[i]) run_op(tv[i].name, tv[i].a, tv[i].b, tv[i].s, tv[i].exp, tv[i].hold);

    // abort while the limb counter reads 7
    in_a = W'(44); in_b = W'(55); in_signed = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    chk("abort in_ready", PW'(in_ready), PW'(1));
    chk("abort out_valid", PW'(out_valid), PW'(0));
    chk("abort out_prod", out_prod, '0);
    no_pulse = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) no_pulse = 1'b0;
    end
    chk("abort no_pulse", PW'(no_pulse), PW'(1));
    run_op("after_abort", W'(44), W'(55), 1'b0, PW'(2420), 0);

    for (int k = 0; k < 24; k++) begin
      for (int j = 0; j < W / 32; j++) begin
        ra[j*32 +: 32] = $urandom;
        rb[j*32 +: 32] = $urandom;
      end
      if ($urandom_range(0, 2) == 0) ra = ra >> $urandom_range(0, W - 1);
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, W - 1);
      if ($urandom_range(0, 3) == 0) ra = -ra;
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", k), ra, rb, rs, ref_mul(ra, rb, rs), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
